xmtr: RTL

//  Serial frame transmitter; upstream partner of the serial frame receiver.

---
 rtl/frame_pkg.sv | 9 +
 rtl/xmtr_if.sv | 14 +
 rtl/xmtr_fifo.sv | 63 ++++++
 rtl/xmtr.sv | 62 ++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: frame format constants and FSM state encodings shared by the serial transmitter and receiver
package frame_pkg;
    localparam int BYTE_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam logic [BYTE_W-1:0] MATCH = 8'hA5;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
endpackage

// File: rtl/xmtr_if.sv
// xmtr_if: parallel write side and serial line of the frame transmitter
interface xmtr_if;
    import frame_pkg::*;
    logic [BYTE_W-1:0] data_in;
    logic writing;
    logic clearing;
    logic serial_out;
    logic framing;
    logic full;
    logic empty;
    logic overflow;
    modport master (output data_in, writing, clearing, input serial_out, framing, full, empty, overflow);
    modport slave  (input data_in, writing, clearing, output serial_out, framing, full, empty, overflow);
endinterface

// File: rtl/xmtr_fifo.sv
// xmtr_fifo: byte buffer; DEPTH-entry circular FIFO with XMTR_FIFO_EN, otherwise a single holding register
module xmtr_fifo import frame_pkg::*;
`ifdef XMTR_FIFO_EN
    #(parameter int DEPTH = 4)
`endif
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              dropped
);
`ifdef XMTR_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic accept;
    // pointers carry a wrap bit so equal indices with differing wrap bits mean full
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = wp == rp;
    assign accept  = push && !full;
    assign dropped = push && full;
    assign rdata   = mem[rp[AW-1:0]];
    // advance write and read pointers independently; both may move on one edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accept) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    // storage needs no reset; empty gates every read
    always_ff @(posedge clock) begin
        if (accept) mem[wp[AW-1:0]] <= wdata;
    end
`else
    logic valid;
    logic [BYTE_W-1:0] hold;
    logic accept;
    // the slot frees on the pop edge, so a write on that same edge still lands
    assign accept  = push && (!valid || pop);
    assign full    = valid;
    assign empty   = !valid;
    assign dropped = push && !accept;
    assign rdata   = hold;
    // single holding register with its valid bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            hold  <= '0;
        end else begin
            valid <= accept || (valid && !pop);
            hold  <= accept ? wdata : hold;
        end
    end
`endif
endmodule

// File: rtl/xmtr.sv
// xmtr: serial frame transmitter (header 8'hA5 then data byte, MSB first); XMTR_FIFO_EN selects a DEPTH-entry FIFO
module xmtr #(
    parameter int GAP = 0
`ifdef XMTR_FIFO_EN
    , parameter int DEPTH = 4
`endif
) (
    input logic   clock,
    input logic   reset,
    xmtr_if.slave bus
);
    import frame_pkg::*;
    logic [1:0] state;
    logic [FRAME_BITS-1:0] shifter;
    logic [3:0] bit_cnt, gap_cnt;
    logic [BYTE_W-1:0] head;
    logic launch, last_bit, gap_done, dropped, full, empty, overflow;
    xmtr_fifo
`ifdef XMTR_FIFO_EN
        #(.DEPTH(DEPTH))
`endif
    u_fifo (
        .clock(clock), .reset(reset), .push(bus.writing), .pop(launch),
        .wdata(bus.data_in), .rdata(head), .full(full), .empty(empty), .dropped(dropped)
    );
    // a new frame may start from IDLE, from the final bit when no gap is configured, or at the end of the gap
    assign last_bit = state == SEND && bit_cnt == 4'(FRAME_BITS - 1);
    assign gap_done = state == frame_pkg::GAP && gap_cnt == 4'(GAP - 1);
    assign launch   = !empty && (state == IDLE || (last_bit && GAP == 0) || gap_done);
    // shifting zeros in leaves the shifter clear once a frame ends, so its MSB is the idle-low line
    assign bus.serial_out = shifter[FRAME_BITS-1];
    assign bus.framing    = state == SEND;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow;
    // frame sequencer: load, shift out 16 bits, optional idle gap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shifter <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (launch) begin
            state   <= SEND;
            shifter <= {MATCH, head};
            bit_cnt <= '0;
        end else if (state == SEND) begin
            shifter <= shifter << 1;
            bit_cnt <= bit_cnt + 1'b1;
            gap_cnt <= '0;
            state   <= last_bit ? ((GAP > 0) ? frame_pkg::GAP : IDLE) : SEND;
        end else if (state == frame_pkg::GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
            state   <= gap_done ? IDLE : frame_pkg::GAP;
        end
    end
    // sticky overflow; clearing wins over a simultaneous dropped write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) overflow <= 1'b0;
        else overflow <= bus.clearing ? 1'b0 : (dropped ? 1'b1 : overflow);
    end
endmodule
